// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack handshake plus the IF/ID-side
// control inputs and head-of-FIFO outputs.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        CE;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;

    modport master (
        output imem_req, imem_addr, inst_out, pc_out, valid_out,
        input  imem_ack, imem_rdata, CE, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_out, pc_out, valid_out,
        output imem_ack, imem_rdata, CE, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, prefetch FIFO, redirect flush.
// Optional FETCH_STATS_EN adds push/flush performance counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    if_fetch_unit_if.master      bus,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [31:0]        fetch_pc, fetch_pc_nxt;
    logic [31:0]        pc_mem   [FIFO_DEPTH];
    logic [31:0]        inst_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               issue, push, pop, valid;

    // Next-state: issue only when a slot is guaranteed at ack time
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        issue        = 1'b0;
        push         = 1'b0;
        unique case (state)
            FETCH: begin
                if (!bus.redirect && (count < CNT_W'(FIFO_DEPTH))) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_ack) begin
                    if (!bus.redirect) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                    state_nxt = FETCH;
                end else if (bus.redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        if (bus.redirect) fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    assign valid = (count != '0);
    assign pop   = valid && bus.CE && !bus.stall && !bus.redirect;

    // FIFO pointers/occupancy; a redirect empties it in the same cycle
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = issue && !rst;
    assign bus.imem_addr = fetch_pc;
    assign bus.valid_out = valid;
    assign bus.inst_out  = valid ? inst_mem[rd_ptr] : NOP_INST;
    assign bus.pc_out    = valid ? pc_mem[rd_ptr]   : 32'h0;

`ifdef FETCH_STATS_EN
    // Flush counted when a redirect discards buffered entries or an in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.redirect && (valid || (state == WAIT)))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized self-checking bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // stimulus controls
    logic        d_rst = 1'b1, d_ce = 1'b1, d_stall = 1'b0, d_redir = 1'b0, d_stray = 1'b0;
    logic [31:0] d_rpc = 32'h0;
    int          fixed_lat = 1;

    // memory responder
    bit          mpend = 1'b0;
    logic [31:0] maddr = 32'h0;
    int          mcnt  = 0;

    // reference model: queue of buffered PCs, next fetch PC, in-flight request
    logic [31:0] mq[$];
    logic [31:0] m_fpc  = RST_PC;
    bit          m_outst = 1'b0, m_stale = 1'b0;
    logic [31:0] m_fcnt = 32'h0, m_flcnt = 32'h0;

    // last sampled outputs
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_inst;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic step();
        logic        exp_req, exp_valid, ack;
        logic [31:0] exp_pc, exp_inst;
        int          lat;
        @(negedge clk);
        rst             = d_rst;
        bus.CE          = d_ce;
        bus.stall       = d_stall;
        bus.redirect    = d_redir;
        bus.redirect_pc = d_rpc;
        ack             = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (d_stray) begin
            ack            = 1'b1;
            bus.imem_rdata = 32'hDEAD_BEEF;
        end else if (mpend) begin
            if (mcnt == 0) begin
                ack            = 1'b1;
                bus.imem_rdata = mem_fn(maddr);
                mpend          = 1'b0;
            end else begin
                mcnt--;
            end
        end
        bus.imem_ack = ack;
        #1;
        exp_valid = (mq.size() != 0);
        exp_pc    = exp_valid ? mq[0] : 32'h0;
        exp_inst  = exp_valid ? mem_fn(mq[0]) : NOP;
        exp_req   = !d_rst && !m_outst && !d_redir && (mq.size() < DEPTH);
        chk("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        chk("pc_out",    bus.pc_out,   exp_pc);
        chk("inst_out",  bus.inst_out, exp_inst);
        chk("imem_req",  32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, m_fpc);
`ifdef FETCH_STATS_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
        chk("perf_flush_cnt", perf_flush_cnt, m_flcnt);
`else
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'h0);
        chk("perf_flush_cnt", perf_flush_cnt, 32'h0);
`endif
        o_req = bus.imem_req; o_addr = bus.imem_addr;
        o_valid = bus.valid_out; o_pc = bus.pc_out; o_inst = bus.inst_out;
        if (bus.imem_req) begin
            lat   = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
            mpend = 1'b1;
            maddr = bus.imem_addr;
            mcnt  = lat - 1;
        end
        if (d_rst) begin
            mq.delete();
            m_fpc = RST_PC; m_outst = 1'b0; m_stale = 1'b0;
            m_fcnt = 32'h0; m_flcnt = 32'h0;
        end else if (d_redir) begin
            if (mq.size() != 0 || (m_outst && !m_stale)) m_flcnt = m_flcnt + 32'd1;
            mq.delete();
            m_fpc = d_rpc;
            if (m_outst) begin
                if (ack) m_outst = 1'b0;
                else     m_stale = 1'b1;
            end
        end else begin
            if (exp_valid && d_ce && !d_stall) void'(mq.pop_front());
            if (m_outst && ack) begin
                if (!m_stale) begin
                    mq.push_back(m_fpc);
                    m_fpc  = m_fpc + 32'd4;
                    m_fcnt = m_fcnt + 32'd1;
                end
                m_outst = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req) begin
                m_outst = 1'b1;
                m_stale = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        d_rst = 1'b1; d_redir = 1'b0; d_stray = 1'b0; mpend = 1'b0;
        step();
        d_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra[$];
        logic [31:0] vp[$];
        int fr, fv, nreq;
        bus.CE = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;

        // reset values
        do_reset();
        chk("rst valid_out", 32'(o_valid), 32'h0);
        chk("rst inst_out",  o_inst, NOP);
        chk("rst pc_out",    o_pc, 32'h0);
        chk("rst imem_req",  32'(o_req), 32'h0);
        chk("rst imem_addr", o_addr, RST_PC);

        // streaming, latency 1
        fixed_lat = 1; d_ce = 1'b1; d_stall = 1'b0;
        fr = -1; fv = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_req) begin ra.push_back(o_addr); if (fr < 0) fr = i; end
            if (o_valid) begin vp.push_back(o_pc); if (fv < 0) fv = i; end
        end
        chk("stream addr0", qget(ra, 0), 32'h0);
        chk("stream addr1", qget(ra, 1), 32'h4);
        chk("stream addr2", qget(ra, 2), 32'h8);
        chk("stream first valid delay", 32'(fv - fr), 32'd2);
        chk("stream pc0", qget(vp, 0), 32'h0);
        chk("stream pc1", qget(vp, 1), 32'h4);

        // stall fills FIFO, then release
        do_reset();
        d_stall = 1'b1; nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_req) nreq++;
            if (i >= 4) chk("stall no req", 32'(o_req), 32'h0);
        end
        chk("stall req count", 32'(nreq), 32'd2);
        chk("stall head pc", o_pc, 32'h0);
        d_stall = 1'b0; vp.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_valid) vp.push_back(o_pc);
        end
        chk("release pc0", qget(vp, 0), 32'h0);
        chk("release pc1", qget(vp, 1), 32'h4);
        chk("release pc2", qget(vp, 2), 32'h8);
        chk("release pc3", qget(vp, 3), 32'hC);

        // redirect with full FIFO, nothing outstanding
        do_reset();
        d_stall = 1'b1;
        repeat (6) step();
        d_redir = 1'b1; d_rpc = 32'h100;
        step();
        d_redir = 1'b0;
        step();
        chk("redir valid", 32'(o_valid), 32'h0);
        chk("redir inst", o_inst, NOP);
        chk("redir req", 32'(o_req), 32'h1);
        chk("redir addr", o_addr, 32'h100);
        step(); step();
        chk("redir first pc", o_pc, 32'h100);
        d_stall = 1'b0;

        // redirect while a request is outstanding (drain)
        do_reset();
        fixed_lat = 3;
        step();
        d_redir = 1'b1; d_rpc = 32'h200;
        step();
        d_redir = 1'b0;
        ra.delete(); vp.delete(); fr = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_req) begin ra.push_back(o_addr); if (fr < 0) fr = i; end
            if (o_valid) vp.push_back(o_pc);
        end
        chk("drain req cycle", 32'(fr), 32'd2);
        chk("drain req addr", qget(ra, 0), 32'h200);
        chk("drain first pc", qget(vp, 0), 32'h200);

        // redirect coincident with ack
        do_reset();
        fixed_lat = 1;
        step();
        d_redir = 1'b1; d_rpc = 32'h300;
        step();
        d_redir = 1'b0;
        step();
        chk("ackredir req", 32'(o_req), 32'h1);
        chk("ackredir addr", o_addr, 32'h300);
        chk("ackredir valid", 32'(o_valid), 32'h0);

        // address wrap
        do_reset();
        d_redir = 1'b1; d_rpc = 32'hFFFF_FFF8;
        step();
        d_redir = 1'b0; ra.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_req) ra.push_back(o_addr);
        end
        chk("wrap addr0", qget(ra, 0), 32'hFFFF_FFF8);
        chk("wrap addr1", qget(ra, 1), 32'hFFFF_FFFC);
        chk("wrap addr2", qget(ra, 2), 32'h0000_0000);
`ifdef FETCH_STATS_EN
        chk("wrap perf_fetch_cnt", perf_fetch_cnt, 32'd3);
`else
        chk("wrap perf_fetch_cnt", perf_fetch_cnt, 32'd0);
`endif

        // randomized traffic with occasional resets followed by a stray ack
        fixed_lat = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] r;
            r       = $urandom;
            d_ce    = (r[2:0] != 3'd0);
            d_stall = (r[5:3] < 3'd2);
            d_redir = (r[9:6] == 4'd0);
            d_rpc   = r[10] ? {16'hFFFF, r[31:18], 2'b00} : {18'h0, r[31:20], 2'b00};
            d_rst   = ($urandom_range(0, 299) == 0);
            step();
            d_stray = d_rst;
            d_rst   = 1'b0;
        end
        d_stray = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that drives the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions with their PCs in a small prefetch FIFO, and presents them to the IF/ID register as inst/PC/valid.
- Honours the IF/ID advance enable, load-use stalls and branch redirects; a redirect flushes all younger, wrong-path fetches.

Parameters:
- RESET_PC, 32'h00000000, fetch PC after reset.
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2).
- NOP_INST, 32'h00000013, bubble encoding ("addi x0, x0, 0") driven when no valid instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high; one clock.
- imem_req  out  1  one-cycle pulse, issues a fetch of imem_addr.
- imem_addr  out  32  word-aligned fetch address, valid with imem_req.
- imem_ack  in  1  one-cycle pulse, imem_rdata valid; earliest 1 cycle after imem_req.
- imem_rdata  in  32  returned instruction.
- CE  in  1  IF/ID register enable; pop permitted only when high.
- stall  in  1  load-use/branch data stall; blocks pop.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  target PC, valid with redirect.
- inst_out  out  32  head instruction, NOP_INST when FIFO empty.
- pc_out  out  32  head PC, 0 when FIFO empty.
- valid_out  out  1  FIFO non-empty.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty.
  - state = FETCH.
  - imem_req = 0, imem_addr = RESET_PC.
  - inst_out = NOP_INST, pc_out = 0, valid_out = 0.
- Reset mid-transaction: any outstanding memory response is ignored. An imem_ack in the cycle after reset is dropped.
- At most one request outstanding.
- FSM:
  - FETCH: if no redirect and (fifo_count + 0) < FIFO_DEPTH, pulse imem_req with imem_addr = fetch_pc, then go to WAIT. Otherwise stay.
  - WAIT: on imem_ack, push {fetch_pc, imem_rdata}, set fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0), go to FETCH.
  - WAIT + redirect without ack: go to DRAIN.
  - WAIT + redirect in the ack cycle: ack data discarded, go to FETCH.
  - DRAIN: wait for the ack of the stale request, discard it, go to FETCH. Nothing is pushed.
- Slot reservation: a request is issued only if a FIFO slot is guaranteed at ack time, i.e. fifo_count < FIFO_DEPTH when issuing. The outstanding request counts as one slot.
- Pop condition: valid_out && CE && !stall && !redirect.
  - Pop and push in the same cycle are both legal when the FIFO is full-minus-reserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Redirect (highest priority, overrides stall/CE):
  - In the same cycle: FIFO flushed (count = 0), fetch_pc <= redirect_pc.
  - Next cycle: valid_out = 0, inst_out = NOP_INST.
  - First request to the target issues the cycle after redirect if no request is outstanding; otherwise after the drained ack.
- Back-to-back redirects: the later one wins; a single DRAIN covers both.
- Stall: FIFO contents and head outputs held; fetching continues until the FIFO is full.
- Full: no request issued. Empty: valid_out = 0, so IF/ID receives bubbles.
- imem_ack in FETCH (no request outstanding) is ignored.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds two 32-bit wrapping counters, exported on output ports perf_fetch_cnt and perf_flush_cnt. Both reset to 0.
  - perf_fetch_cnt increments on each push.
  - perf_flush_cnt increments once per redirect that discards ≥1 FIFO entry or drains an ack.
- Undefined: perf_fetch_cnt and perf_flush_cnt are driven constant 0. No counter logic is present.

Test Plan:
- Reset, memory ack latency 1, CE = 1, stall = 0 -> imem_addr sequence 0x0, 0x4, 0x8. pc_out/inst_out follow in order; valid_out first high 2 cycles after the first req.
- stall = 1 for 6 cycles with FIFO_DEPTH = 2 -> at most 2 pushes, then imem_req stays 0. Head PC is held constant. After release, PCs continue with no gap or duplicate.
- redirect to 0x100 while FIFO holds 0x8, 0xC and no request outstanding -> next cycle valid_out = 0. The next imem_addr is 0x100, and pc_out = 0x100 is the first valid output.
- redirect to 0x200 while a request to 0x10 is outstanding, ack latency 3 -> the 0x10 data is never output. The request to 0x200 issues the cycle after the stale ack.
- redirect in the same cycle as the ack -> data discarded. The next cycle issues the target request; FSM never enters DRAIN.
- RESET_PC = 0xFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. With FETCH_STATS_EN, perf_fetch_cnt = 3.
